// File: rtl/pipeline_step_ctrl_pkg.sv
// Debug/pipeline constants shared by the step controller and the debug unit:
// command codes, controller state encoding and the state-to-output decode.
package pipeline_step_ctrl_pkg;

  localparam logic [1:0] CMD_NOP        = 2'd0;
  localparam logic [1:0] CMD_RUN        = 2'd1;
  localparam logic [1:0] CMD_STEP       = 2'd2;
  localparam logic [1:0] CMD_STOP_CLEAR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic step;
    logic pc_freeze;
    logic running;
    logic done;
    logic cmd_ready;
  } ctrl_t;

  // Moore output decode; evaluated on the next state so outputs come straight from flops.
  function automatic ctrl_t decode_state(state_t s);
    ctrl_t c;
    c.step      = (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    c.pc_freeze = (s == ST_DRAIN) || (s == ST_DONE);
    c.running   = (s == ST_RUN) || (s == ST_DRAIN);
    c.done      = (s == ST_DONE);
    c.cmd_ready = (s == ST_IDLE) || (s == ST_RUN) || (s == ST_DONE);
    return c;
  endfunction

endpackage

// File: rtl/pipeline_step_ctrl.sv
// Debug run/step/halt controller generating the pipeline-wide step enable,
// PC freeze, flush and a saturating count of stepped cycles.
module pipeline_step_ctrl
  import pipeline_step_ctrl_pkg::*;
#(
  parameter int NB           = 32,
  parameter int NB_CMD       = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [NB_CMD-1:0] i_cmd,
  input  logic              i_halt,
  output logic              o_cmd_ready,
  output logic              o_step,
  output logic              o_pc_freeze,
  output logic              o_flush,
  output logic              o_running,
  output logic              o_done,
  output logic [NB-1:0]     o_cycle_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt;
  logic          clear_nxt;
  logic          cmd_acc;
  ctrl_t         ctrl;

  assign cmd_acc = i_cmd_valid && o_cmd_ready;

  assign o_step      = ctrl.step;
  assign o_pc_freeze = ctrl.pc_freeze;
  assign o_running   = ctrl.running;
  assign o_done      = ctrl.done;
  assign o_cmd_ready = ctrl.cmd_ready;

  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_acc && i_cmd == NB_CMD'(CMD_RUN))             state_nxt = ST_RUN;
        else if (cmd_acc && i_cmd == NB_CMD'(CMD_STEP))       state_nxt = ST_STEP;
        else if (cmd_acc && i_cmd == NB_CMD'(CMD_STOP_CLEAR)) clear_nxt = 1'b1;
      end
      ST_RUN: begin
        // HALT outranks a same-cycle STOP_CLEAR; the command is simply dropped.
        if (i_halt)                                           state_nxt = ST_DRAIN;
        else if (cmd_acc && i_cmd == NB_CMD'(CMD_STOP_CLEAR)) state_nxt = ST_IDLE;
      end
      ST_STEP:  state_nxt = i_halt ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (drain_cnt <= DW'(1)) state_nxt = ST_DONE;
      ST_DONE: begin
        if (cmd_acc && i_cmd == NB_CMD'(CMD_STOP_CLEAR)) begin
          state_nxt = ST_IDLE;
          clear_nxt = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      ctrl          <= decode_state(ST_IDLE);
      drain_cnt     <= '0;
      o_cycle_count <= '0;
      o_flush       <= 1'b0;
    end else begin
      state   <= state_nxt;
      ctrl    <= decode_state(state_nxt);
      o_flush <= clear_nxt;

      if (clear_nxt)
        o_cycle_count <= '0;
      else if (o_step && o_cycle_count != {NB{1'b1}})
        o_cycle_count <= o_cycle_count + 1'b1;

      // Load on entry so DRAIN lasts exactly DRAIN_CYCLES cycles.
      if (state_nxt == ST_DRAIN && state != ST_DRAIN)
        drain_cnt <= DW'(DRAIN_CYCLES);
      else if (state == ST_DRAIN)
        drain_cnt <= drain_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Directed bench for pipeline_step_ctrl: a vector table for single-cycle behaviour
// plus hand sequences for run/halt/drain, reset mid-drain and counter saturation.
module tb_pipeline_step_ctrl;

  localparam logic [1:0] NOP = 2'd0, RUN = 2'd1, STP = 2'd2, CLR = 2'd3;

  logic        clk = 1'b0;
  logic        rst, vld, halt;
  logic [1:0]  cmd;
  logic        rdy, step, frz, fl, run, done;
  logic [31:0] cnt;
  logic        rdy4, step4, frz4, fl4, run4, done4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_step_ctrl #(.NB(32), .NB_CMD(2), .DRAIN_CYCLES(3)) dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(vld), .i_cmd(cmd), .i_halt(halt),
    .o_cmd_ready(rdy), .o_step(step), .o_pc_freeze(frz), .o_flush(fl),
    .o_running(run), .o_done(done), .o_cycle_count(cnt)
  );

  pipeline_step_ctrl #(.NB(4), .NB_CMD(2), .DRAIN_CYCLES(3)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(vld), .i_cmd(cmd), .i_halt(halt),
    .o_cmd_ready(rdy4), .o_step(step4), .o_pc_freeze(frz4), .o_flush(fl4),
    .o_running(run4), .o_done(done4), .o_cycle_count(cnt4)
  );

  typedef struct {
    logic       rst, vld;
    logic [1:0] cmd;
    logic       halt;
    logic       step, frz, fl, run, done, rdy;
    int         cnt;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(logic r, logic v, logic [1:0] c, logic h,
                              logic s, logic f, logic l, logic u, logic d, logic y, int n);
    vec_t t;
    t.rst = r; t.vld = v; t.cmd = c; t.halt = h;
    t.step = s; t.frz = f; t.fl = l; t.run = u; t.done = d; t.rdy = y; t.cnt = n;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] c, input logic h);
    rst = r; vld = v; cmd = c; halt = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flush must never overlap a step cycle.
  always @(negedge clk) begin
    if (fl === 1'b1 && step === 1'b1) begin
      errors++;
      $display("FAIL flush_with_step actual=1 expected=0");
    end
  end

  initial begin
    drive(1'b1, 1'b0, NOP, 1'b0);

    //           rst vld cmd  hlt  step frz fl run done rdy cnt
    tbl[0]  = mk(1, 0, NOP, 0,   0, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(0, 1, STP, 0,   1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, NOP, 0,   0, 0, 0, 0, 0, 1, 1);
    tbl[3]  = mk(0, 1, STP, 0,   1, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(0, 1, RUN, 0,   0, 0, 0, 0, 0, 1, 2);
    tbl[5]  = mk(0, 1, STP, 0,   1, 0, 0, 0, 0, 0, 2);
    tbl[6]  = mk(0, 0, NOP, 0,   0, 0, 0, 0, 0, 1, 3);
    tbl[7]  = mk(0, 1, CLR, 1,   0, 0, 1, 0, 0, 1, 0);
    tbl[8]  = mk(0, 1, NOP, 0,   0, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 1, RUN, 0,   1, 0, 0, 1, 0, 1, 0);
    tbl[10] = mk(0, 1, STP, 0,   1, 0, 0, 1, 0, 1, 1);
    tbl[11] = mk(0, 1, CLR, 0,   0, 0, 0, 0, 0, 1, 2);
    tbl[12] = mk(0, 1, RUN, 0,   1, 0, 0, 1, 0, 1, 2);
    tbl[13] = mk(0, 1, CLR, 1,   1, 1, 0, 1, 0, 0, 3);
    tbl[14] = mk(0, 1, STP, 0,   1, 1, 0, 1, 0, 0, 4);
    tbl[15] = mk(0, 1, CLR, 0,   1, 1, 0, 1, 0, 0, 5);
    tbl[16] = mk(0, 0, NOP, 0,   0, 1, 0, 0, 1, 1, 6);
    tbl[17] = mk(0, 1, RUN, 0,   0, 1, 0, 0, 1, 1, 6);
    tbl[18] = mk(0, 1, STP, 1,   0, 1, 0, 0, 1, 1, 6);
    tbl[19] = mk(0, 1, CLR, 0,   0, 0, 1, 0, 0, 1, 0);
    tbl[20] = mk(0, 0, NOP, 0,   0, 0, 0, 0, 0, 1, 0);
    tbl[21] = mk(0, 1, STP, 0,   1, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk(0, 0, NOP, 1,   1, 1, 0, 1, 0, 0, 1);
    tbl[23] = mk(0, 0, NOP, 0,   1, 1, 0, 1, 0, 0, 2);
    tbl[24] = mk(0, 0, NOP, 0,   1, 1, 0, 1, 0, 0, 3);
    tbl[25] = mk(0, 0, NOP, 0,   0, 1, 0, 0, 1, 1, 4);
    tbl[26] = mk(1, 1, CLR, 0,   0, 0, 0, 0, 0, 1, 0);

    tick();
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].cmd, tbl[i].halt);
      tick();
      chk($sformatf("row%0d_step", i),  32'(step), 32'(tbl[i].step));
      chk($sformatf("row%0d_frz", i),   32'(frz),  32'(tbl[i].frz));
      chk($sformatf("row%0d_flush", i), 32'(fl),   32'(tbl[i].fl));
      chk($sformatf("row%0d_run", i),   32'(run),  32'(tbl[i].run));
      chk($sformatf("row%0d_done", i),  32'(done), 32'(tbl[i].done));
      chk($sformatf("row%0d_rdy", i),   32'(rdy),  32'(tbl[i].rdy));
      chk($sformatf("row%0d_cnt", i),   cnt,       32'(tbl[i].cnt));
    end

    // RUN for 10 cycles with HALT on the 10th, then 3 drain cycles.
    drive(1'b1, 1'b0, NOP, 1'b0); tick();
    drive(1'b0, 1'b1, RUN, 1'b0); tick();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b0, NOP, k == 10);
      tick();
    end
    drive(1'b0, 1'b0, NOP, 1'b0);
    chk("halt_drain_entry_cnt", cnt, 32'd10);
    chk("halt_drain_entry_frz", 32'(frz), 32'd1);
    tick(); tick();
    chk("halt_drain_last_step", 32'(step), 32'd1);
    tick();
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_done_cnt", cnt, 32'd13);
    chk("halt_done_frz", 32'(frz), 32'd1);
    chk("halt_done_step", 32'(step), 32'd0);

    // Reset during the second drain cycle.
    drive(1'b1, 1'b0, NOP, 1'b0); tick();
    drive(1'b0, 1'b1, RUN, 1'b0); tick();
    drive(1'b0, 1'b0, NOP, 1'b1); tick();
    drive(1'b0, 1'b0, NOP, 1'b0); tick();
    chk("rstdrain_pre_frz", 32'(frz), 32'd1);
    drive(1'b1, 1'b1, STP, 1'b1); tick();
    drive(1'b0, 1'b0, NOP, 1'b0);
    chk("rstdrain_step", 32'(step), 32'd0);
    chk("rstdrain_frz", 32'(frz), 32'd0);
    chk("rstdrain_run", 32'(run), 32'd0);
    chk("rstdrain_cnt", cnt, 32'd0);
    chk("rstdrain_rdy", 32'(rdy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rstdrain_nodone%0d", k), 32'(done), 32'd0);
    end

    // 4-bit counter saturation, and STEP during DRAIN ignored.
    drive(1'b1, 1'b0, NOP, 1'b0); tick();
    drive(1'b0, 1'b1, RUN, 1'b0); tick();
    drive(1'b0, 1'b0, NOP, 1'b0);
    for (int k = 0; k < 20; k++) tick();
    chk("sat_cnt4", 32'(cnt4), 32'd15);
    chk("sat_cnt32", cnt, 32'd20);
    drive(1'b0, 1'b0, NOP, 1'b1); tick();
    drive(1'b0, 1'b1, STP, 1'b0); tick();
    chk("sat_drain_frz4", 32'(frz4), 32'd1);
    tick();
    drive(1'b0, 1'b0, NOP, 1'b0); tick();
    chk("sat_done4", 32'(done4), 32'd1);
    chk("sat_done_step4", 32'(step4), 32'd0);
    chk("sat_done_cnt4", 32'(cnt4), 32'd15);
    tick();
    chk("sat_still_done4", 32'(done4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_step_ctrl.md
PIPELINE_STEP_CTRL -- requirements
Module: pipeline_step_ctrl

Interface
REQ-001 Parameter NB, default 32, width of cycle counter.
REQ-002 Parameter NB_CMD, default 2, width of debug command code.
REQ-003 Parameter DRAIN_CYCLES, default 3, cycles stepped after HALT to retire older instructions (EX, MEM, WB); legal range 1..15.
REQ-004 i_clk  in  1  single clock; block SHALL update on posedge so outputs are stable at the negedge used by the pipeline registers.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_cmd_valid  in  1  command strobe from debug unit.
REQ-007 i_cmd  in  NB_CMD  0=NOP, 1=RUN, 2=STEP, 3=STOP_CLEAR.
REQ-008 i_halt  in  1  HALT decoded in ID stage.
REQ-009 o_cmd_ready  out  1  command accepted this cycle when high with i_cmd_valid.
REQ-010 o_step  out  1  global enable for PC and all intermediate pipeline registers.
REQ-011 o_pc_freeze  out  1  holds PC, injects bubble into IF/ID.
REQ-012 o_flush  out  1  one-cycle flush to all intermediate registers.
REQ-013 o_running  out  1  high in RUN or DRAIN.
REQ-014 o_done  out  1  program finished.
REQ-015 o_cycle_count  out  NB  number of cycles with o_step high.

Function
REQ-016 FSM states IDLE, RUN, STEP, DRAIN, DONE; all outputs SHALL decode from registered state/counters only (Moore, no input-to-output path).
REQ-017 IDLE: o_cmd_ready=1; RUN->RUN; STEP->STEP; STOP_CLEAR->stay IDLE, o_cycle_count<=0, o_flush=1 next cycle; NOP->IDLE.
REQ-018 RUN: o_step=1 every cycle; o_cmd_ready=1; i_halt->DRAIN with drain counter=DRAIN_CYCLES; STOP_CLEAR->IDLE without flush or counter clear (pause); RUN/STEP ignored.
REQ-019 RUN with i_halt and STOP_CLEAR in same cycle: i_halt SHALL win (->DRAIN), command dropped.
REQ-020 STEP: lasts exactly one cycle with o_step=1, o_cmd_ready=0; then IDLE, or DRAIN if i_halt high in that cycle.
REQ-021 i_halt SHALL be sampled only in RUN and STEP; ignored in all other states.
REQ-022 DRAIN: o_step=1, o_pc_freeze=1, o_cmd_ready=0; drain counter decrements each cycle; counter==1 -> DONE; total DRAIN duration exactly DRAIN_CYCLES cycles; commands ignored.
REQ-023 DONE: o_step=0, o_pc_freeze=1, o_done=1, o_cmd_ready=1; STOP_CLEAR->IDLE with o_cycle_count<=0 and one-cycle o_flush; RUN/STEP ignored.
REQ-024 o_cycle_count SHALL increment by 1 on every cycle o_step=1 and saturate at 2^NB-1 (no wrap).
REQ-025 o_flush SHALL never coincide with o_step=1.
REQ-026 Commands with i_cmd_valid=1 while o_cmd_ready=0 SHALL be discarded, not queued.

Reset
REQ-027 On i_reset at posedge: state IDLE, drain counter 0, o_cycle_count 0, o_step 0, o_pc_freeze 0, o_flush 0, o_running 0, o_done 0, o_cmd_ready 1 next cycle.
REQ-028 Reset SHALL take priority over any command or i_halt in the same cycle, including mid-DRAIN.

Structure
REQ-029 Command codes (RUN, STEP, STOP_CLEAR, NOP) and state encodings SHALL live in the shared debug/pipeline constants include, used also by the debug unit.
REQ-030 Single module, no sub-modules; drain counter width $clog2(DRAIN_CYCLES+1).

Verification
REQ-031 Reset, then STEP x3 -> three isolated one-cycle o_step pulses, o_cycle_count=3, state IDLE.
REQ-032 RUN, i_halt at cycle 10 -> o_step high 10 RUN cycles + 3 DRAIN cycles, o_done=1, o_cycle_count=13, o_pc_freeze=1.
REQ-033 RUN with i_halt and STOP_CLEAR same cycle -> DRAIN entered, DONE after 3 cycles.
REQ-034 DONE, STOP_CLEAR -> o_flush=1 for exactly one cycle, o_step=0, o_cycle_count=0, state IDLE.
REQ-035 i_reset asserted at DRAIN cycle 2 -> next cycle all outputs 0, o_done never asserted.
REQ-036 NB=4, RUN 20 cycles -> o_cycle_count holds 15; STEP issued during DRAIN -> ignored.
